// File: rtl/cmp_seq_ctrl_pkg.sv
// Shared definitions for the sequential equality controller: FSM encoding and
// the slice-index width helper.
package cmp_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index width for nslice slices; never below one bit so a single-slice
    // build still has a legal port.
    function automatic int slice_w(input int nslice);
        return (nslice < 2) ? 1 : $clog2(nslice);
    endfunction

endpackage

// File: rtl/igual_2b2b.sv
// 2-bit equality cell: out is high when {a,b} equals {c,d}.
module igual_2b2b (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic out
);

    assign out = (a ~^ c) & (b ~^ d);

endmodule

// File: rtl/cmp_seq_ctrl.sv
// Multi-bit equality compare that walks a single 2-bit cell across the operands,
// LSB slice first, stopping at the first mismatching slice.
module cmp_seq_ctrl
    import cmp_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                abort,
    input  logic [WIDTH-1:0]                    a,
    input  logic [WIDTH-1:0]                    b,
    output logic                                busy,
    output logic                                done,
    output logic                                equal,
    output logic [slice_w(WIDTH/2)-1:0]         slice_idx
);

    localparam int NSLICE = WIDTH / 2;
    localparam int IW     = slice_w(NSLICE);

    state_t            state;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [1:0]        a_sl;
    logic [1:0]        b_sl;
    logic              cell_eq;
    logic              last_slice;

    // Slice mux feeding the shared cell.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (slice_idx == IW'(i)) begin
                a_sl = a_q[2*i +: 2];
                b_sl = b_q[2*i +: 2];
            end
        end
    end

    igual_2b2b u_cell (
        .a   (a_sl[1]),
        .b   (a_sl[0]),
        .c   (b_sl[1]),
        .d   (b_sl[0]),
        .out (cell_eq)
    );

    assign last_slice = (slice_idx == IW'(NSLICE - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            equal     <= 1'b0;
            slice_idx <= '0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q       <= a;
                        b_q       <= b;
                        slice_idx <= '0;
                        equal     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= CMP;
                    end
                end
                CMP: begin
                    // Abort wins even on the final slice, so no result is published.
                    if (abort) begin
                        busy  <= 1'b0;
                        equal <= 1'b0;
                        state <= IDLE;
                    end else if (!cell_eq || last_slice) begin
                        equal <= cell_eq;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        slice_idx <= slice_idx + IW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Directed and randomized checks of cmp_seq_ctrl against a cycle-count model
// derived from the first differing 2-bit slice.
module tb_cmp_seq_ctrl;

    localparam int WIDTH  = 8;
    localparam int NSLICE = WIDTH / 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             equal;
    logic [1:0]       slice_idx;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cmp_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .equal     (equal),
        .slice_idx (slice_idx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Index of the lowest differing slice, NSLICE if the operands are equal.
    function automatic int first_diff(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        for (int i = 0; i < NSLICE; i++)
            if ((((x ^ y) >> (2 * i)) & WIDTH'(3)) != '0) return i;
        return NSLICE;
    endfunction

    function automatic int cmp_cycles(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int j;
        j = first_diff(x, y);
        return (j == NSLICE) ? NSLICE : j + 1;
    endfunction

    // Starts one comparison from IDLE and checks every cycle through the
    // return to IDLE. abort_at: cycle (1-based after accept) holding abort, 0 = none.
    // noise: keep start high and scramble a/b while the compare is running.
    task automatic run_cmp(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           input int abort_at, input bit noise);
        int  last_cmp, end_c;
        bit  match, aborted;
        match    = (first_diff(av, bv) == NSLICE);
        last_cmp = cmp_cycles(av, bv);
        aborted  = (abort_at >= 1) && (abort_at <= last_cmp);
        if (aborted) last_cmp = abort_at;
        end_c = last_cmp + 1;

        start = 1'b1; a = av; b = bv; abort = 1'b0;
        tick();
        for (int c = 1; c <= end_c; c++) begin
            chk("busy",  32'(busy),  32'(c <= last_cmp));
            chk("done",  32'(done),  32'((c == end_c) && !aborted));
            chk("equal", 32'(equal), 32'((c == end_c) && !aborted && match));
            if (c <= last_cmp) chk("slice_idx", 32'(slice_idx), 32'(c - 1));
            else               chk("slice_idx_end", 32'(slice_idx), 32'(last_cmp - 1));
            start = noise && (c < end_c || !aborted);
            abort = (c == abort_at);
            if (noise) begin
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
            end
            tick();
        end
        chk("idle_busy",  32'(busy),  32'(0));
        chk("idle_done",  32'(done),  32'(0));
        chk("idle_equal", 32'(equal), 32'(match && !aborted));
        chk("idle_slice", 32'(slice_idx), 32'(last_cmp - 1));
        abort = 1'b0;
        start = noise;
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        int               sel, ab;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0;
        tick(); tick();
        chk("rst_busy",  32'(busy),  32'(0));
        chk("rst_done",  32'(done),  32'(0));
        chk("rst_equal", 32'(equal), 32'(0));
        chk("rst_slice", 32'(slice_idx), 32'(0));
        rst_n = 1'b1;
        tick();

        run_cmp(8'hA5, 8'hA5, 0, 1'b0);   // full match, done at cycle 5
        start = 1'b0; tick();
        chk("equal_held", 32'(equal), 32'(1));

        // Reset in the middle of a compare
        start = 1'b1; a = 8'h3C; b = 8'h3C;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("rstmid_busy",  32'(busy),  32'(0));
        chk("rstmid_done",  32'(done),  32'(0));
        chk("rstmid_equal", 32'(equal), 32'(0));
        chk("rstmid_slice", 32'(slice_idx), 32'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rstmid_nodone", 32'(done), 32'(0));
            chk("rstmid_nobusy", 32'(busy), 32'(0));
        end

        run_cmp(8'hA5, 8'hA4, 0, 1'b0);   // slice 0 mismatch
        run_cmp(8'hA5, 8'h95, 0, 1'b0);   // slice 2 mismatch
        run_cmp(8'hFF, 8'hFF, 4, 1'b0);   // abort on last slice
        run_cmp(8'h5A, 8'h5A, 0, 1'b1);   // start and operand churn while busy
        run_cmp(8'h5A, 8'h5B, 0, 1'b1);   // back-to-back with start held
        run_cmp(8'hC3, 8'hC3, 0, 1'b1);
        run_cmp(8'h0F, 8'h1F, 0, 1'b1);
        start = 1'b0; tick();

        for (int n = 0; n < 60; n++) begin
            ra  = WIDTH'($urandom);
            sel = $urandom_range(0, 2);
            if (sel == 0)      rb = ra;
            else if (sel == 1) rb = ra ^ (WIDTH'($urandom_range(1, 3)) << (2 * $urandom_range(0, NSLICE - 1)));
            else               rb = WIDTH'($urandom);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, cmp_cycles(ra, rb)) : 0;
            run_cmp(ra, rb, ab, 1'($urandom_range(0, 1)));
        end
        start = 1'b0; tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
